cve2_branch_predict_bht: RTL and testbench



---
 rtl/cve2_pkg.sv | 27 ++
 rtl/cve2_branch_decode.sv | 38 +++
 rtl/cve2_branch_predict_bht.sv | 109 ++++++++++
 tb/tb_cve2_branch_predict_bht.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// cve2_pkg: shared opcode encodings and branch-predictor helpers. Rev 1.0
`default_nettype none
package cve2_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'h03,
    OPCODE_OP_IMM = 7'h13,
    OPCODE_STORE  = 7'h23,
    OPCODE_OP     = 7'h33,
    OPCODE_BRANCH = 7'h63,
    OPCODE_JALR   = 7'h67,
    OPCODE_JAL    = 7'h6f
  } opcode_e;

  // Compressed quadrant-1 funct3 values for the control-transfer instructions
  localparam logic [2:0] C1_FUNCT3_JAL  = 3'b001;
  localparam logic [2:0] C1_FUNCT3_J    = 3'b101;
  localparam logic [2:0] C1_FUNCT3_BEQZ = 3'b110;
  localparam logic [2:0] C1_FUNCT3_BNEZ = 3'b111;

  // Weakly not-taken: MSB clear, all lower bits set
  function automatic int bp_ctr_init(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_branch_decode.sv
// cve2_branch_decode: control-transfer type flags and sign-extended immediate. Rev 1.0
`default_nettype none
module cve2_branch_decode
  import cve2_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        instr_b_o,
  output logic        instr_j_o,
  output logic        instr_cb_o,
  output logic        instr_cj_o,
  output logic [31:0] imm_o
);

  logic [31:0] imm_b, imm_j, imm_cb, imm_cj;

  always_comb begin
    instr_b_o  = (instr_i[6:0] == OPCODE_BRANCH);
    instr_j_o  = (instr_i[6:0] == OPCODE_JAL);
    instr_cb_o = (instr_i[1:0] == 2'b01) &&
                 ((instr_i[15:13] == C1_FUNCT3_BEQZ) || (instr_i[15:13] == C1_FUNCT3_BNEZ));
    instr_cj_o = (instr_i[1:0] == 2'b01) &&
                 ((instr_i[15:13] == C1_FUNCT3_JAL) || (instr_i[15:13] == C1_FUNCT3_J));

    imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    imm_j  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    imm_cb = {{24{instr_i[12]}}, instr_i[6:5], instr_i[2], instr_i[11:10], instr_i[4:3], 1'b0};
    imm_cj = {{21{instr_i[12]}}, instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
              instr_i[2], instr_i[11], instr_i[5:3], 1'b0};

    // Falls back to the B-type immediate so the target stays deterministic
    imm_o = imm_b;
    if (instr_j_o)       imm_o = imm_j;
    else if (instr_cb_o) imm_o = imm_cb;
    else if (instr_cj_o) imm_o = imm_cj;
  end

endmodule
`default_nettype wire

// File: rtl/cve2_branch_predict_bht.sv
// cve2_branch_predict_bht: saturating-counter BHT predictor for the IF stage. Rev 1.0
// Build option CVE2_BP_GSHARE_EN: XOR the table index with retired global history.
`default_nettype none
module cve2_branch_predict_bht
  import cve2_pkg::*;
#(
  parameter  int unsigned BhtEntries   = 64,
  parameter  int unsigned CounterWidth = 2,
  parameter  int unsigned GhrWidth     = 8,
  localparam int unsigned IdxW         = $clog2(BhtEntries)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     fetch_rdata_i,
  input  logic [31:0]     fetch_pc_i,
  input  logic            fetch_valid_i,
  output logic            predict_branch_taken_o,
  output logic [31:0]     predict_branch_pc_o,
  output logic [IdxW-1:0] predict_idx_o,
  input  logic            update_valid_i,
  input  logic [IdxW-1:0] update_idx_i,
  input  logic            update_taken_i
);

  localparam logic [CounterWidth-1:0] CtrInit = CounterWidth'(bp_ctr_init(CounterWidth));
  localparam logic [CounterWidth-1:0] CtrMax  = '1;

  logic        instr_b, instr_j, instr_cb, instr_cj;
  logic [31:0] imm;

  cve2_branch_decode u_decode (
    .instr_i    (fetch_rdata_i),
    .instr_b_o  (instr_b),
    .instr_j_o  (instr_j),
    .instr_cb_o (instr_cb),
    .instr_cj_o (instr_cj),
    .imm_o      (imm)
  );

  logic [GhrWidth-1:0] ghr;
  logic [IdxW-1:0]     ghr_idx;
  logic [IdxW-1:0]     idx;

`ifdef CVE2_BP_GSHARE_EN
  logic [GhrWidth-1:0] ghr_q, ghr_d;

  // History follows resolved outcomes only, so flushes never need to undo it
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid_i) ghr_d = {ghr_q[GhrWidth-2:0], update_taken_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign ghr = ghr_q;
`else
  assign ghr = '0;
`endif

  if (GhrWidth > IdxW) begin : g_ghr_trunc
    logic unused_ghr_hi;
    assign unused_ghr_hi = ^ghr[GhrWidth-1:IdxW];
    assign ghr_idx       = ghr[IdxW-1:0];
  end else if (GhrWidth == IdxW) begin : g_ghr_exact
    assign ghr_idx = ghr;
  end else begin : g_ghr_zext
    assign ghr_idx = {{(IdxW-GhrWidth){1'b0}}, ghr};
  end

  assign idx = fetch_pc_i[IdxW:1] ^ ghr_idx;

  logic [CounterWidth-1:0] ctr_q [BhtEntries];
  logic [CounterWidth-1:0] ctr_d [BhtEntries];

  always_comb begin
    ctr_d = ctr_q;
    if (update_valid_i) begin
      if (update_taken_i && (ctr_q[update_idx_i] != CtrMax)) begin
        ctr_d[update_idx_i] = ctr_q[update_idx_i] + 1'b1;
      end else if (!update_taken_i && (ctr_q[update_idx_i] != '0)) begin
        ctr_d[update_idx_i] = ctr_q[update_idx_i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BhtEntries; i++) ctr_q[i] <= CtrInit;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Reads the registered counter: a same-cycle update is not bypassed
  assign predict_branch_taken_o = fetch_valid_i &
      (instr_j | instr_cj | ((instr_b | instr_cb) & ctr_q[idx][CounterWidth-1]));
  assign predict_branch_pc_o    = fetch_pc_i + imm;
  assign predict_idx_o          = idx;

`ifndef SYNTHESIS
  decode_onehot0_a: assert property (@(posedge clk_i) disable iff (rst_i)
      fetch_valid_i |-> $onehot0({instr_b, instr_j, instr_cb, instr_cj}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cve2_branch_predict_bht.sv
// tb_cve2_branch_predict_bht: directed self-checking bench for the BHT predictor. Rev 1.0
`default_nettype none
`timescale 1ns/1ps
module tb_cve2_branch_predict_bht;

  localparam int IdxW = 6;

  localparam logic [31:0] BEQ_P16  = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] CJ_P4    = 32'h0000_A011;  // c.j +4
  localparam logic [31:0] CBNEZ_M2 = 32'h0000_FC7D;  // c.bnez x8,-2
  localparam logic [31:0] CBEQZ_0  = 32'h0000_C001;  // c.beqz x8,0

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     fetch_rdata;
  logic [31:0]     fetch_pc;
  logic            fetch_valid;
  logic            taken;
  logic [31:0]     target;
  logic [IdxW-1:0] pidx;
  logic            update_valid;
  logic [IdxW-1:0] update_idx;
  logic            update_taken;

  int n_checks = 0;
  int n_errors = 0;

  cve2_branch_predict_bht dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .fetch_rdata_i          (fetch_rdata),
    .fetch_pc_i             (fetch_pc),
    .fetch_valid_i          (fetch_valid),
    .predict_branch_taken_o (taken),
    .predict_branch_pc_o    (target),
    .predict_idx_o          (pidx),
    .update_valid_i         (update_valid),
    .update_idx_i           (update_idx),
    .update_taken_i         (update_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic vld);
    fetch_pc    = pc;
    fetch_rdata = instr;
    fetch_valid = vld;
    #1;
  endtask

  task automatic upd(input logic [IdxW-1:0] i, input logic t);
    update_valid = 1'b1;
    update_idx   = i;
    update_taken = t;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    fetch_rdata  = '0;
    fetch_pc     = '0;
    fetch_valid  = 1'b0;
    update_valid = 1'b0;
    update_idx   = '0;
    update_taken = 1'b0;
    do_reset();

    // Decode and target generation straight out of reset
    fetch(32'h100, BEQ_P16, 1'b1);
    chk("beq_taken", 32'(taken), 32'd0);
    chk("beq_pc", target, 32'h110);
    chk("beq_idx", 32'(pidx), 32'h00);
    fetch(32'h200, JAL_M8, 1'b1);
    chk("jal_taken", 32'(taken), 32'd1);
    chk("jal_pc", target, 32'h1F8);
    fetch(32'h202, CJ_P4, 1'b1);
    chk("cj_taken", 32'(taken), 32'd1);
    chk("cj_pc", target, 32'h206);
    chk("cj_idx", 32'(pidx), 32'h01);
    fetch(32'h000, CBNEZ_M2, 1'b1);
    chk("cbnez_taken", 32'(taken), 32'd0);
    chk("cbnez_pc_wrap", target, 32'hFFFF_FFFE);
    fetch(32'h00A, JAL_M8, 1'b0);
    chk("novalid_taken", 32'(taken), 32'd0);
    chk("novalid_idx", 32'(pidx), 32'h05);

`ifdef CVE2_BP_GSHARE_EN
    // Three taken outcomes shift 0b111 into the history
    fetch(32'h00A, BEQ_P16, 1'b1);
    upd(6'd5, 1'b1);
    upd(6'd5, 1'b1);
    upd(6'd5, 1'b1);
    chk("gs_idx_hashed", 32'(pidx), 32'h02);
    chk("gs_taken_idx2", 32'(taken), 32'd0);
    fetch(32'h004, BEQ_P16, 1'b1);
    chk("gs_idx_pc4", 32'(pidx), 32'h05);
    chk("gs_taken_idx5", 32'(taken), 32'd1);
    upd(6'd0, 1'b0);
    fetch(32'h00A, BEQ_P16, 1'b1);
    chk("gs_idx_shift0", 32'(pidx), 32'h0B);
    do_reset();
    chk("gs_idx_after_rst", 32'(pidx), 32'h05);
    chk("gs_taken_after_rst", 32'(taken), 32'd0);
`else
    // Training idx 5 through the whole counter range
    fetch(32'h00A, BEQ_P16, 1'b1);
    upd(6'd5, 1'b1);
    chk("train_t1", 32'(taken), 32'd1);
    upd(6'd5, 1'b1);
    chk("train_t2", 32'(taken), 32'd1);
    upd(6'd5, 1'b1);
    chk("train_sat_hi", 32'(taken), 32'd1);
    upd(6'd5, 1'b0);
    chk("train_n1", 32'(taken), 32'd1);
    upd(6'd5, 1'b0);
    chk("train_n2", 32'(taken), 32'd0);
    upd(6'd5, 1'b0);
    upd(6'd5, 1'b0);
    upd(6'd5, 1'b1);
    chk("train_sat_lo", 32'(taken), 32'd0);
    upd(6'd5, 1'b1);
    chk("train_recover", 32'(taken), 32'd1);
    upd(6'd5, 1'b0);

    // Same-cycle read and update of idx 5 (counter 01): no bypass
    fetch(32'h00A, CBEQZ_0, 1'b1);
    chk("cbeqz_pc", target, 32'h00A);
    update_valid = 1'b1;
    update_idx   = 6'd5;
    update_taken = 1'b1;
    #1;
    chk("same_cycle_old", 32'(taken), 32'd0);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    #1;
    chk("same_cycle_new", 32'(taken), 32'd1);

    // Reset mid-training, with an update held during the reset edge
    fetch(32'h006, BEQ_P16, 1'b1);
    chk("idx3", 32'(pidx), 32'h03);
    upd(6'd3, 1'b1);
    upd(6'd3, 1'b1);
    chk("idx3_trained", 32'(taken), 32'd1);
    rst          = 1'b1;
    update_valid = 1'b1;
    update_idx   = 6'd3;
    update_taken = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    update_valid = 1'b0;
    #1;
    chk("rst_idx3", 32'(taken), 32'd0);
    upd(6'd3, 1'b1);
    chk("rst_idx3_init01", 32'(taken), 32'd1);
    fetch(32'h00A, BEQ_P16, 1'b1);
    chk("rst_idx5", 32'(taken), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
